// File: rtl/cpu_types_pkg.sv
// Shared CPU types: BTB entry layout, 2-bit branch counter encodings and the IF/ID latch record.
package cpu_types_pkg;

    // Widest tag, reached when the BTB has the minimum index width; narrower tags are zero-extended.
    localparam int unsigned TAG_MAX_W = 30;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        ctr_t                 counter;
    } btb_entry_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        pred_taken;
        logic        valid;
    } ifid_t;

    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == ST) ? ST : ctr_t'(c + 2'b01);
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == SNT) ? SNT : ctr_t'(c - 2'b01);
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookups are combinational and see the pre-update contents; updates commit at the clock edge.
module branch_target_buffer
    import cpu_types_pkg::*;
#(
    parameter int unsigned BTB_DEPTH = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] lookup_pc,
    output logic        lookup_taken,
    output logic [31:0] lookup_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int unsigned IDX_W = $clog2(BTB_DEPTH);

    btb_entry_t entries_q [BTB_DEPTH];

    logic [IDX_W-1:0]     l_idx, u_idx;
    logic [TAG_MAX_W-1:0] l_tag, u_tag;
    btb_entry_t           l_entry, u_entry, wr_entry;
    logic                 l_hit, u_hit, wr_en;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign l_tag = TAG_MAX_W'(lookup_pc >> (IDX_W + 2));
    assign u_tag = TAG_MAX_W'(upd_pc >> (IDX_W + 2));

    assign l_entry = entries_q[l_idx];
    assign u_entry = entries_q[u_idx];
    assign l_hit   = l_entry.valid && (l_entry.tag == l_tag);
    assign u_hit   = u_entry.valid && (u_entry.tag == u_tag);

    assign lookup_taken  = l_hit && l_entry.counter[1];
    assign lookup_target = l_entry.target;

    always_comb begin
        wr_en    = 1'b0;
        wr_entry = u_entry;
        if (upd_valid) begin
            if (u_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    wr_entry.counter = ctr_inc(u_entry.counter);
                    wr_entry.target  = upd_target;
                end else begin
                    wr_entry.counter = ctr_dec(u_entry.counter);
                end
            end else if (upd_taken) begin
                // Not-taken misses never allocate, so cold branches don't evict useful entries.
                wr_en    = 1'b1;
                wr_entry = '{valid: 1'b1, tag: u_tag, target: upd_target, counter: WT};
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < int'(BTB_DEPTH); i++) begin
                entries_q[i] <= '{valid: 1'b0, tag: '0, target: '0, counter: WNT};
            end
        end else if (wr_en) begin
            entries_q[u_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC prediction and the IF/ID pipeline latch.
// Define FETCH_BTB_EN to build in the branch target buffer; otherwise fetch is strictly sequential.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT   = 32'h0,
    parameter int unsigned BTB_DEPTH = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic [31:0] imemaddr,
    output logic        imemREN,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_npc,
    output logic        ifid_pred_taken,
    output logic        ifid_valid
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] pred_npc;
    logic        pred_taken;
    ifid_t       ifid_q, ifid_d;

    assign imemaddr = pc_q;
    assign imemREN  = 1'b1;
    assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_BTB_EN
    logic [31:0] btb_target;

    branch_target_buffer #(
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .CLK           (CLK),
        .nRST          (nRST),
        .lookup_pc     (pc_q),
        .lookup_taken  (pred_taken),
        .lookup_target (btb_target),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target)
    );

    assign pred_npc = pred_taken ? btb_target : pc_plus4;
`else
    localparam int unsigned unused_btb_depth = BTB_DEPTH;
    logic unused_upd;

    assign unused_upd = ^{upd_valid, upd_pc, upd_taken, upd_target};
    assign pred_taken = 1'b0;
    assign pred_npc   = pc_plus4;
`endif

    // A resolved redirect from MEM outranks every local hold condition.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (ihit) begin
            pc_d = pred_npc;
        end
    end

    always_comb begin
        ifid_d = ifid_q;
        if (redirect || flush) begin
            ifid_d = '0;
        end else if (stall) begin
            ifid_d = ifid_q;
        end else if (ihit) begin
            ifid_d = '{instr: imemload, pc: pc_q, npc: pc_plus4, pred_taken: pred_taken,
                       valid: 1'b1};
        end else begin
            ifid_d.valid = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q   <= PC_INIT;
            ifid_q <= '0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign ifid_instr      = ifid_q.instr;
    assign ifid_pc         = ifid_q.pc;
    assign ifid_npc        = ifid_q.npc;
    assign ifid_pred_taken = ifid_q.pred_taken;
    assign ifid_valid      = ifid_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector bench for fetch_unit; expectations cover both the BTB and the sequential build.
module tb_fetch_unit;

`ifdef FETCH_BTB_EN
    localparam bit BTB_ON = 1'b1;
`else
    localparam bit BTB_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, stall, flush, redirect;
    logic [31:0] imemload, redirect_pc;
    logic        upd_valid, upd_taken;
    logic [31:0] upd_pc, upd_target;
    logic [31:0] imemaddr;
    logic        imemREN;
    logic [31:0] ifid_instr, ifid_pc, ifid_npc;
    logic        ifid_pred_taken, ifid_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_unit #(
        .PC_INIT   (32'h0),
        .BTB_DEPTH (16)
    ) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .ihit            (ihit),
        .imemload        (imemload),
        .imemaddr        (imemaddr),
        .imemREN         (imemREN),
        .stall           (stall),
        .flush           (flush),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_npc        (ifid_npc),
        .ifid_pred_taken (ifid_pred_taken),
        .ifid_valid      (ifid_valid)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        s, f, r;
        logic [31:0] rpc;
        logic        h;
        logic [31:0] ld;
        logic        uv;
        logic [31:0] upc;
        logic        utk;
        logic [31:0] utgt;
        logic [31:0] addr_btb, addr_base;
        logic [31:0] ins, ipc, inpc;
        logic        pred_btb, val;
    } vec_t;

    function automatic vec_t mk(input logic s, f, r, input logic [31:0] rpc, input logic h,
                                input logic [31:0] ld, input logic uv, input logic [31:0] upc,
                                input logic utk, input logic [31:0] utgt,
                                input logic [31:0] ab, an, ins, ipc, inpc,
                                input logic pb, val);
        vec_t v;
        v.s = s; v.f = f; v.r = r; v.rpc = rpc; v.h = h; v.ld = ld;
        v.uv = uv; v.upc = upc; v.utk = utk; v.utgt = utgt;
        v.addr_btb = ab; v.addr_base = an; v.ins = ins; v.ipc = ipc; v.inpc = inpc;
        v.pred_btb = pb; v.val = val;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        stall = v.s; flush = v.f; redirect = v.r; redirect_pc = v.rpc;
        ihit = v.h; imemload = v.ld;
        upd_valid = v.uv; upd_pc = v.upc; upd_taken = v.utk; upd_target = v.utgt;
        @(posedge CLK);
        @(negedge CLK);
        check32({tag, " imemaddr"}, imemaddr, BTB_ON ? v.addr_btb : v.addr_base);
        check32({tag, " ifid_instr"}, ifid_instr, v.ins);
        check32({tag, " ifid_pc"}, ifid_pc, v.ipc);
        check32({tag, " ifid_npc"}, ifid_npc, v.inpc);
        check32({tag, " ifid_pred_taken"}, 32'(ifid_pred_taken), 32'(BTB_ON & v.pred_btb));
        check32({tag, " ifid_valid"}, 32'(ifid_valid), 32'(v.val));
    endtask

    vec_t vecs[34];

    initial begin
        // stall flush redir rpc  ihit load  uv upc utk utgt  addr(btb) addr(base)  ifid fields
        vecs[0]  = mk(0,0,0,0,          1,'hA0, 0,0,0,0,       'h4,'h4,   'hA0,'h0,'h4,0,1);
        vecs[1]  = mk(0,0,0,0,          1,'hA1, 0,0,0,0,       'h8,'h8,   'hA1,'h4,'h8,0,1);
        vecs[2]  = mk(1,0,0,0,          1,'hA2, 0,0,0,0,       'h8,'h8,   'hA1,'h4,'h8,0,1);
        vecs[3]  = mk(0,0,0,0,          0,'hA2, 0,0,0,0,       'h8,'h8,   'hA1,'h4,'h8,0,0);
        vecs[4]  = mk(0,1,0,0,          1,'hA2, 0,0,0,0,       'hC,'hC,   0,0,0,0,0);
        vecs[5]  = mk(1,0,1,'h40,       0,0,    0,0,0,0,       'h40,'h40, 0,0,0,0,0);
        vecs[6]  = mk(0,0,0,0,          1,'hA3, 0,0,0,0,       'h44,'h44, 'hA3,'h40,'h44,0,1);
        vecs[7]  = mk(0,0,1,'h10,       1,'hA4, 0,0,0,0,       'h10,'h10, 0,0,0,0,0);
        vecs[8]  = mk(0,0,0,0,          1,'hB0, 1,'h10,1,'h80, 'h14,'h14, 'hB0,'h10,'h14,0,1);
        vecs[9]  = mk(0,0,1,'h10,       0,0,    0,0,0,0,       'h10,'h10, 0,0,0,0,0);
        vecs[10] = mk(0,0,0,0,          1,'hB0, 0,0,0,0,       'h80,'h14, 'hB0,'h10,'h14,1,1);
        vecs[11] = mk(0,0,1,'h10,       0,0,    1,'h10,0,0,    'h10,'h10, 0,0,0,0,0);
        vecs[12] = mk(1,0,0,0,          0,0,    1,'h10,0,0,    'h10,'h10, 0,0,0,0,0);
        vecs[13] = mk(0,1,0,0,          0,0,    1,'h10,0,0,    'h10,'h10, 0,0,0,0,0);
        vecs[14] = mk(0,0,0,0,          1,'hB0, 0,0,0,0,       'h14,'h14, 'hB0,'h10,'h14,0,1);
        vecs[15] = mk(0,0,1,'h10,       0,0,    1,'h10,1,'h80, 'h10,'h10, 0,0,0,0,0);
        vecs[16] = mk(0,0,0,0,          0,0,    1,'h10,1,'h80, 'h10,'h10, 0,0,0,0,0);
        vecs[17] = mk(0,0,0,0,          0,0,    1,'h10,1,'h80, 'h10,'h10, 0,0,0,0,0);
        vecs[18] = mk(0,0,0,0,          0,0,    1,'h10,1,'h80, 'h10,'h10, 0,0,0,0,0);
        vecs[19] = mk(0,0,0,0,          1,'hB1, 0,0,0,0,       'h80,'h14, 'hB1,'h10,'h14,1,1);
        vecs[20] = mk(0,0,1,'h10,       0,0,    1,'h10,0,0,    'h10,'h10, 0,0,0,0,0);
        vecs[21] = mk(0,0,0,0,          1,'hB1, 0,0,0,0,       'h80,'h14, 'hB1,'h10,'h14,1,1);
        vecs[22] = mk(0,0,1,'h50,       0,0,    0,0,0,0,       'h50,'h50, 0,0,0,0,0);
        vecs[23] = mk(0,0,0,0,          1,'hC0, 0,0,0,0,       'h54,'h54, 'hC0,'h50,'h54,0,1);
        vecs[24] = mk(0,0,1,'h50,       0,0,    1,'h50,0,0,    'h50,'h50, 0,0,0,0,0);
        vecs[25] = mk(0,0,0,0,          1,'hC0, 0,0,0,0,       'h54,'h54, 'hC0,'h50,'h54,0,1);
        vecs[26] = mk(0,0,1,'h10,       0,0,    0,0,0,0,       'h10,'h10, 0,0,0,0,0);
        vecs[27] = mk(0,0,0,0,          1,'hB2, 0,0,0,0,       'h80,'h14, 'hB2,'h10,'h14,1,1);
        vecs[28] = mk(0,0,1,'h50,       0,0,    1,'h50,1,'hC0, 'h50,'h50, 0,0,0,0,0);
        vecs[29] = mk(0,0,0,0,          1,'hC1, 0,0,0,0,       'hC0,'h54, 'hC1,'h50,'h54,1,1);
        vecs[30] = mk(0,0,1,'h10,       0,0,    0,0,0,0,       'h10,'h10, 0,0,0,0,0);
        vecs[31] = mk(0,0,0,0,          1,'hB3, 0,0,0,0,       'h14,'h14, 'hB3,'h10,'h14,0,1);
        vecs[32] = mk(0,0,1,'hFFFFFFFC, 0,0,    0,0,0,0,       'hFFFFFFFC,'hFFFFFFFC, 0,0,0,0,0);
        vecs[33] = mk(0,0,0,0,          1,'hD0, 0,0,0,0,       'h0,'h0,   'hD0,'hFFFFFFFC,'h0,0,1);

        nRST = 1'b0;
        ihit = 0; stall = 0; flush = 0; redirect = 0; redirect_pc = 0; imemload = 0;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
        repeat (2) @(negedge CLK);
        check32("reset imemaddr", imemaddr, 32'h0);
        check32("reset imemREN", 32'(imemREN), 32'h1);
        check32("reset ifid_instr", ifid_instr, 32'h0);
        check32("reset ifid_pc", ifid_pc, 32'h0);
        check32("reset ifid_npc", ifid_npc, 32'h0);
        check32("reset ifid_valid", 32'(ifid_valid), 32'h0);
        nRST = 1'b1;

        for (int i = 0; i < 34; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted mid-cycle with a fetch and a taken update in flight.
        run_vec(mk(0,0,1,'h20, 0,0, 0,0,0,0, 'h20,'h20, 0,0,0,0,0), "rst_pre0");
        run_vec(mk(0,0,0,0, 1,'hE0, 0,0,0,0, 'h24,'h24, 'hE0,'h20,'h24,0,1), "rst_pre1");
        ihit = 1; imemload = 'hE1;
        upd_valid = 1; upd_pc = 'h10; upd_taken = 1; upd_target = 'h80;
        #2 nRST = 1'b0;
        #1;
        check32("async rst imemaddr", imemaddr, 32'h0);
        check32("async rst ifid_valid", 32'(ifid_valid), 32'h0);
        check32("async rst ifid_instr", ifid_instr, 32'h0);
        @(negedge CLK);
        check32("held rst imemaddr", imemaddr, 32'h0);
        nRST = 1'b1;
        run_vec(mk(0,0,0,0, 1,'hF0, 0,0,0,0, 'h4,'h4, 'hF0,'h0,'h4,0,1), "post_rst0");
        run_vec(mk(0,0,1,'h10, 0,0, 0,0,0,0, 'h10,'h10, 0,0,0,0,0), "post_rst1");
        run_vec(mk(0,0,0,0, 1,'hF1, 0,0,0,0, 'h14,'h14, 'hF1,'h10,'h14,0,1), "post_rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
